// File: rtl/list_enabled_item_ids.sv
// rtl/list_enabled_item_ids.sv - rotating priority compactor listing enabled item indices from a start position
// Optional output registers: define LIST_ENABLED_ITEM_ID_REG_OUT_EN.
module list_enabled_item_ids #(
    parameter int  ITEM_NUM = 8,
    localparam int W        = $clog2(ITEM_NUM)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ITEM_NUM-1:0] seq,
    input  logic [W-1:0]        start_pos,
    output logic [W-1:0]        enabled_item_id    [0:ITEM_NUM-1],
    output logic [W:0]          enabled_item_num,
    output logic [W-1:0]        enabled_item_id_q  [0:ITEM_NUM-1],
    output logic [W:0]          enabled_item_num_q
);

    logic [ITEM_NUM-1:0] rot;
    logic [W:0]          pre [0:ITEM_NUM];

    // W-bit index arithmetic wraps modulo ITEM_NUM since ITEM_NUM is a power of two.
    always_comb begin
        for (int i = 0; i < ITEM_NUM; i++) begin
            rot[i] = seq[start_pos + W'(i)];
        end
    end

    always_comb begin
        pre[0] = '0;
        for (int i = 0; i < ITEM_NUM; i++) begin
            pre[i+1] = pre[i] + (W+1)'(rot[i]);
        end
    end

    assign enabled_item_num = pre[ITEM_NUM];

    // Each enabled rotated slot lands in the output slot given by its prefix count.
    always_comb begin
        for (int j = 0; j < ITEM_NUM; j++) begin
            enabled_item_id[j] = '0;
        end
        for (int i = 0; i < ITEM_NUM; i++) begin
            if (rot[i]) begin
                enabled_item_id[pre[i][W-1:0]] = start_pos + W'(i);
            end
        end
    end

`ifdef LIST_ENABLED_ITEM_ID_REG_OUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < ITEM_NUM; j++) begin
                enabled_item_id_q[j] <= '0;
            end
            enabled_item_num_q <= '0;
        end else begin
            for (int j = 0; j < ITEM_NUM; j++) begin
                enabled_item_id_q[j] <= enabled_item_id[j];
            end
            enabled_item_num_q <= enabled_item_num;
        end
    end
`else
    logic unused_clk_rst;
    assign unused_clk_rst = &{1'b0, clk, rst};

    always_comb begin
        for (int j = 0; j < ITEM_NUM; j++) begin
            enabled_item_id_q[j] = enabled_item_id[j];
        end
        enabled_item_num_q = enabled_item_num;
    end
`endif

endmodule

// File: tb/tb_list_enabled_item_ids.sv
// tb/tb_list_enabled_item_ids.sv - self-checking bench for list_enabled_item_ids (either LIST_ENABLED_ITEM_ID_REG_OUT_EN build)
module tb_list_enabled_item_ids;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] seq = '0;
    logic [W-1:0] start_pos = '0;
    logic [W-1:0] enabled_item_id    [0:N-1];
    logic [W:0]   enabled_item_num;
    logic [W-1:0] enabled_item_id_q  [0:N-1];
    logic [W:0]   enabled_item_num_q;

    int n_cmp = 0;
    int n_bad = 0;

    int exp_ids [N];
    int exp_num;
    int prev_ids [N];
    int prev_num;

    always #5 clk = ~clk;

    list_enabled_item_ids #(.ITEM_NUM(N)) dut (
        .clk                (clk),
        .rst                (rst),
        .seq                (seq),
        .start_pos          (start_pos),
        .enabled_item_id    (enabled_item_id),
        .enabled_item_num   (enabled_item_num),
        .enabled_item_id_q  (enabled_item_id_q),
        .enabled_item_num_q (enabled_item_num_q)
    );

    // Reference: walk positions start_pos, start_pos+1, ... modulo N and queue the enabled ones.
    function automatic void compute_expected(input logic [N-1:0] s, input int sp);
        int found[$];
        for (int k = 0; k < N; k++) begin
            int p;
            p = (sp + k) % N;
            if (s[p]) found.push_back(p);
        end
        exp_num = found.size();
        for (int j = 0; j < N; j++) exp_ids[j] = (j < exp_num) ? found[j] : 0;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        seq = 8'b1010_0110;
        start_pos = 3'd5;
        compute_expected(seq, 5);
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (enabled_item_id[j] !== W'(exp_ids[j])) begin
                n_bad++;
                $display("FAIL reset_comb_id[%0d]: got %0d expected %0d", j, enabled_item_id[j], exp_ids[j]);
            end
        end
`ifdef LIST_ENABLED_ITEM_ID_REG_OUT_EN
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (enabled_item_id_q[j] !== '0) begin
                n_bad++;
                $display("FAIL reset_id_q[%0d]: got %0d expected 0", j, enabled_item_id_q[j]);
            end
        end
        n_cmp++;
        if (enabled_item_num_q !== '0) begin
            n_bad++;
            $display("FAIL reset_num_q: got %0d expected 0", enabled_item_num_q);
        end
`else
        n_cmp++;
        if (enabled_item_num_q !== (W+1)'(exp_num)) begin
            n_bad++;
            $display("FAIL reset_num_q_passthru: got %0d expected %0d", enabled_item_num_q, exp_num);
        end
`endif
    endtask

    task automatic test_vectors();
        logic [N-1:0] tv_seq [5];
        int           tv_sp  [5];
        int           tv_ids [5][N];
        int           tv_num [5];
        tv_seq[0] = 8'b1010_0110; tv_sp[0] = 0; tv_ids[0] = '{1, 2, 5, 7, 0, 0, 0, 0}; tv_num[0] = 4;
        tv_seq[1] = 8'b1010_0110; tv_sp[1] = 5; tv_ids[1] = '{5, 7, 1, 2, 0, 0, 0, 0}; tv_num[1] = 4;
        tv_seq[2] = 8'hFF;        tv_sp[2] = 3; tv_ids[2] = '{3, 4, 5, 6, 7, 0, 1, 2}; tv_num[2] = 8;
        tv_seq[3] = 8'h00;        tv_sp[3] = 6; tv_ids[3] = '{0, 0, 0, 0, 0, 0, 0, 0}; tv_num[3] = 0;
        tv_seq[4] = 8'h80;        tv_sp[4] = 7; tv_ids[4] = '{7, 0, 0, 0, 0, 0, 0, 0}; tv_num[4] = 1;
        for (int t = 0; t < 5; t++) begin
            seq = tv_seq[t];
            start_pos = W'(tv_sp[t]);
            #1;
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (enabled_item_id[j] !== W'(tv_ids[t][j])) begin
                    n_bad++;
                    $display("FAIL vec%0d_id[%0d]: got %0d expected %0d", t, j, enabled_item_id[j], tv_ids[t][j]);
                end
            end
            n_cmp++;
            if (enabled_item_num !== (W+1)'(tv_num[t])) begin
                n_bad++;
                $display("FAIL vec%0d_num: got %0d expected %0d", t, enabled_item_num, tv_num[t]);
            end
        end
    endtask

    task automatic test_all_ones();
        seq = '1;
        for (int sp = 0; sp < N; sp++) begin
            start_pos = W'(sp);
            #1;
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (enabled_item_id[j] !== W'((sp + j) % N)) begin
                    n_bad++;
                    $display("FAIL ones_sp%0d_id[%0d]: got %0d expected %0d", sp, j, enabled_item_id[j], (sp + j) % N);
                end
            end
            n_cmp++;
            if (enabled_item_num !== (W+1)'(N)) begin
                n_bad++;
                $display("FAIL ones_sp%0d_num: got %0d expected %0d", sp, enabled_item_num, N);
            end
        end
    endtask

    task automatic test_pipeline();
`ifdef LIST_ENABLED_ITEM_ID_REG_OUT_EN
        int want [N];
        want = '{5, 7, 1, 2, 0, 0, 0, 0};
        @(negedge clk);
        rst = 1'b0;
        seq = 8'b1010_0110;
        start_pos = 3'd5;
        @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (enabled_item_id_q[j] !== W'(want[j])) begin
                n_bad++;
                $display("FAIL pipe_id_q[%0d]: got %0d expected %0d", j, enabled_item_id_q[j], want[j]);
            end
        end
        n_cmp++;
        if (enabled_item_num_q !== 4'd4) begin
            n_bad++;
            $display("FAIL pipe_num_q: got %0d expected 4", enabled_item_num_q);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) begin
            n_cmp++;
            if (enabled_item_id_q[j] !== '0) begin
                n_bad++;
                $display("FAIL rearm_id_q[%0d]: got %0d expected 0", j, enabled_item_id_q[j]);
            end
        end
        n_cmp++;
        if (enabled_item_num_q !== '0) begin
            n_bad++;
            $display("FAIL rearm_num_q: got %0d expected 0", enabled_item_num_q);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] s;
        int           sp;
        s = N'($urandom);
        sp = int'($urandom_range(N - 1));
        @(negedge clk);
        seq = s;
        start_pos = W'(sp);
        compute_expected(s, sp);
        prev_ids = exp_ids;
        prev_num = exp_num;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            s = N'($urandom);
            sp = int'($urandom_range(N - 1));
            seq = s;
            start_pos = W'(sp);
            compute_expected(s, sp);
            #1;
`ifdef LIST_ENABLED_ITEM_ID_REG_OUT_EN
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (enabled_item_id_q[j] !== W'(prev_ids[j])) begin
                    n_bad++;
                    $display("FAIL b2b%0d_id_q[%0d]: got %0d expected %0d", c, j, enabled_item_id_q[j], prev_ids[j]);
                end
            end
            n_cmp++;
            if (enabled_item_num_q !== (W+1)'(prev_num)) begin
                n_bad++;
                $display("FAIL b2b%0d_num_q: got %0d expected %0d", c, enabled_item_num_q, prev_num);
            end
`else
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (enabled_item_id_q[j] !== W'(exp_ids[j])) begin
                    n_bad++;
                    $display("FAIL b2b%0d_id_q[%0d]: got %0d expected %0d", c, j, enabled_item_id_q[j], exp_ids[j]);
                end
            end
`endif
            prev_ids = exp_ids;
            prev_num = exp_num;
        end
    endtask

    task automatic test_random();
        logic [N-1:0] s;
        int           sp;
        for (int it = 0; it < 65536; it++) begin
            @(negedge clk);
            s = N'($urandom);
            sp = int'($urandom_range(N - 1));
            seq = s;
            start_pos = W'(sp);
            compute_expected(s, sp);
            #1;
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (enabled_item_id[j] !== W'(exp_ids[j])) begin
                    n_bad++;
                    $display("FAIL rand%0d_id[%0d] seq=%b sp=%0d: got %0d expected %0d", it, j, s, sp, enabled_item_id[j], exp_ids[j]);
                end
            end
            n_cmp++;
            if (enabled_item_num !== (W+1)'(exp_num)) begin
                n_bad++;
                $display("FAIL rand%0d_num seq=%b: got %0d expected %0d", it, s, enabled_item_num, exp_num);
            end
            @(posedge clk);
            #1;
            for (int j = 0; j < N; j++) begin
                n_cmp++;
                if (enabled_item_id_q[j] !== W'(exp_ids[j])) begin
                    n_bad++;
                    $display("FAIL rand%0d_id_q[%0d] seq=%b sp=%0d: got %0d expected %0d", it, j, s, sp, enabled_item_id_q[j], exp_ids[j]);
                end
            end
            n_cmp++;
            if (enabled_item_num_q !== (W+1)'(exp_num)) begin
                n_bad++;
                $display("FAIL rand%0d_num_q seq=%b: got %0d expected %0d", it, s, enabled_item_num_q, exp_num);
            end
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_all_ones();
        test_pipeline();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
